// File: rtl/usb_rx_packet_sequencer.sv
// USB receive packet sequencer: SYNC, PID, payload packing, CRC/length check.
// Define USB_RX_PID_CHECK_EN to require the PID upper nibble to be ~PID.
module usb_rx_packet_sequencer #(
   parameter int MAX_BYTES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_received,
   input  logic [7:0]  rx_byte,
   input  logic        eop,
   input  logic        crc_ok,
   input  logic        fifo_full,
   output logic        receiving,
   output logic        crc_clear,
   output logic        packet_type,
   output logic [3:0]  pid,
   output logic [15:0] rx_data,
   output logic        write_enable,
   output logic        packet_done,
   output logic        rcv_error
);
   localparam int CW = $clog2(MAX_BYTES + 3);
   localparam logic [CW-1:0] TOKEN_LIM = CW'(2);
   localparam logic [CW-1:0] DATA_LIM = CW'(MAX_BYTES + 2);

   typedef enum logic [2:0] {
      IDLE, PID, PAYLOAD, CHECK, DONE, ERR
   } state_t;

   typedef enum logic [1:0] {
      K_TOKEN, K_DATA, K_HS
   } kind_t;

   state_t        state, state_n;
   kind_t         kind, kind_n;
   logic [CW-1:0] count, count_n, limit;
   logic          ended, ended_n;
   logic          crc_good, crc_good_n;
   logic          receiving_n, crc_clear_n, type_n;
   logic          we_n, done_n, err_n;
   logic [3:0]    pid_n;
   logic [15:0]   data_n;
   logic          pid_ok, byte_err, pass;

`ifdef USB_RX_PID_CHECK_EN
   assign pid_ok = (rx_byte[7:4] == ~rx_byte[3:0]);
`else
   assign pid_ok = 1'b1;
`endif

   assign limit = (kind == K_DATA)  ? DATA_LIM :
                  (kind == K_TOKEN) ? TOKEN_LIM : '0;

   assign pass = (kind == K_HS) ? (count == '0) :
                 crc_good && ((kind == K_TOKEN) ? (count == TOKEN_LIM)
                                                : (count >= TOKEN_LIM));

   always_comb begin
      state_n     = state;
      kind_n      = kind;
      count_n     = count;
      ended_n     = ended;
      crc_good_n  = crc_good;
      receiving_n = receiving;
      crc_clear_n = 1'b0;
      type_n      = packet_type;
      pid_n       = pid;
      data_n      = rx_data;
      we_n        = 1'b0;
      done_n      = 1'b0;
      err_n       = rcv_error;
      byte_err    = 1'b0;
      // Remember the packet end so ERR can leave even if eop came earlier
      if (state != IDLE && eop) begin
         ended_n    = 1'b1;
         crc_good_n = crc_ok;
      end
      unique case (state)
         IDLE: begin
            if (byte_received) begin
               if (rx_byte == 8'h80) begin
                  state_n     = PID;
                  crc_clear_n = 1'b1;
                  err_n       = 1'b0;
                  receiving_n = 1'b1;
                  count_n     = '0;
                  ended_n     = 1'b0;
               end else begin
                  byte_err = 1'b1;
               end
            end
         end
         PID: begin
            if (byte_received) begin
               pid_n   = rx_byte[3:0];
               state_n = eop ? CHECK : PAYLOAD;
               case (rx_byte[3:0])
                  4'h1, 4'h9, 4'hD, 4'h5: begin
                     kind_n = K_TOKEN;
                     type_n = 1'b0;
                  end
                  4'h3, 4'hB: begin
                     kind_n = K_DATA;
                     type_n = 1'b1;
                  end
                  4'h2, 4'hA, 4'hE: begin
                     kind_n = K_HS;
                     type_n = 1'b0;
                  end
                  default: byte_err = 1'b1;
               endcase
               if (!pid_ok) byte_err = 1'b1;
            end else if (eop) begin
               byte_err = 1'b1;
            end
         end
         PAYLOAD: begin
            if (byte_received) begin
               if (count == limit) begin
                  byte_err = 1'b1;
               end else begin
                  count_n = count + 1'b1;
                  if (!count[0]) begin
                     data_n[7:0] = rx_byte;
                  end else begin
                     data_n[15:8] = rx_byte;
                     if (fifo_full) byte_err = 1'b1;
                     else we_n = 1'b1;
                  end
               end
            end
            if (eop && !byte_err) begin
               state_n = CHECK;
               if (count_n[0]) begin
                  data_n[15:8] = 8'h00;
                  if (fifo_full) byte_err = 1'b1;
                  else we_n = 1'b1;
               end
            end
         end
         CHECK: begin
            if (pass) begin
               state_n     = DONE;
               done_n      = 1'b1;
               receiving_n = 1'b0;
            end else begin
               byte_err = 1'b1;
            end
         end
         DONE: state_n = IDLE;
         ERR: begin
            if (eop || ended) begin
               state_n     = IDLE;
               receiving_n = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
      if (byte_err) begin
         state_n = ERR;
         err_n   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         kind         <= K_TOKEN;
         count        <= '0;
         ended        <= 1'b0;
         crc_good     <= 1'b0;
         receiving    <= 1'b0;
         crc_clear    <= 1'b0;
         packet_type  <= 1'b0;
         pid          <= '0;
         rx_data      <= '0;
         write_enable <= 1'b0;
         packet_done  <= 1'b0;
         rcv_error    <= 1'b0;
      end else begin
         state        <= state_n;
         kind         <= kind_n;
         count        <= count_n;
         ended        <= ended_n;
         crc_good     <= crc_good_n;
         receiving    <= receiving_n;
         crc_clear    <= crc_clear_n;
         packet_type  <= type_n;
         pid          <= pid_n;
         rx_data      <= data_n;
         write_enable <= we_n;
         packet_done  <= done_n;
         rcv_error    <= err_n;
      end
   end

endmodule
